rotor_step_ctrl: RTL and testbench

ROTOR_STEP_CTRL -- requirements
Module: rotor_step_ctrl

---
 rtl/enigma_pkg.sv | 32 +++
 rtl/rotor_pos_inc.sv | 25 ++
 rtl/rotor_step_ctrl.sv | 142 ++++++++++++++
 tb/tb_rotor_step_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma rotor datapath.
//
// Contents:
//   LETTER_W, ALPHA_SIZE  letter width and alphabet size (A..Z = 0..25)
//   letter_t              one alphabet letter / rotor position
//   NOTCH_I..NOTCH_V      turnover positions of the historical rotors I..V
//   out_state_t           occupancy of the one-entry output register
//   is_letter()           true when a 5-bit code is a real letter (0..25)
package enigma_pkg;

  localparam int LETTER_W   = 5;
  localparam int ALPHA_SIZE = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  // Position at which each rotor kicks its left-hand neighbour.
  localparam letter_t NOTCH_I   = letter_t'(16);  // Q
  localparam letter_t NOTCH_II  = letter_t'(4);   // E
  localparam letter_t NOTCH_III = letter_t'(21);  // V
  localparam letter_t NOTCH_IV  = letter_t'(9);   // J
  localparam letter_t NOTCH_V   = letter_t'(25);  // Z

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic logic is_letter(input letter_t l);
    return l < letter_t'(ALPHA_SIZE);
  endfunction

endpackage

// File: rtl/rotor_pos_inc.sv
// Combinational mod-26 rotor position increment.
//
// Ports:
//   pos       in   current position, 0..25
//   en        in   advance the rotor by one position
//   pos_next  out  pos+1 mod 26 when en, otherwise pos
module rotor_pos_inc
  import enigma_pkg::*;
(
  input  letter_t pos,
  input  logic    en,
  output letter_t pos_next
);

  localparam letter_t LAST = letter_t'(ALPHA_SIZE - 1);

  // Z wraps straight to A; codes 26..31 are never produced.
  always_comb begin
    pos_next = pos;
    if (en) begin
      pos_next = (pos == LAST) ? letter_t'(0) : pos + letter_t'(1);
    end
  end

endmodule

// File: rtl/rotor_step_ctrl.sv
// Enigma three-rotor stepping controller with a one-entry output register.
//
// Every accepted character advances the rotors (with the middle-rotor
// double step) and is handed downstream together with the rotor positions
// that must be used to encipher it.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   load, r1_init..r3_init       load start positions (0..25)
//   in_valid, in_char, in_ready  input character handshake
//   out_valid, out_ready         output handshake
//   out_char                     accepted character, unchanged
//   r1_out, r2_out, r3_out       post-step rotor positions for out_char
//   out_err                      out_char was not a letter; no step taken
//   load_err                     sticky: a load carried an init value > 25
module rotor_step_ctrl
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH3 = NOTCH_III,
  parameter letter_t NOTCH2 = NOTCH_II
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  letter_t r1_init,
  input  letter_t r2_init,
  input  letter_t r3_init,
  input  logic    in_valid,
  input  letter_t in_char,
  output logic    in_ready,
  output logic    out_valid,
  input  logic    out_ready,
  output letter_t out_char,
  output letter_t r1_out,
  output letter_t r2_out,
  output letter_t r3_out,
  output logic    out_err,
  output logic    load_err
);

  out_state_t state, state_next;

  letter_t r1, r2, r3;
  letter_t r1_next, r2_next, r3_next;

  logic accept;
  logic char_ok;
  logic step_en;
  logic en2, en1;
  logic init_ok;

  assign out_valid = (state == OUT_FULL);
  assign in_ready  = !load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign char_ok   = is_letter(in_char);
  assign init_ok   = is_letter(r1_init) && is_letter(r2_init) && is_letter(r3_init);

  // A non-letter is still accepted and passed through, but must not move
  // the rotors.
  assign step_en = accept && char_ok;

  // All decisions use the pre-step positions. The middle rotor also steps
  // when it sits on its own notch, which is what produces the double step.
  assign en2 = step_en && ((r3 == NOTCH3) || (r2 == NOTCH2));
  assign en1 = step_en && (r2 == NOTCH2);

  rotor_pos_inc u_inc1 (.pos(r1), .en(en1),     .pos_next(r1_next));
  rotor_pos_inc u_inc2 (.pos(r2), .en(en2),     .pos_next(r2_next));
  rotor_pos_inc u_inc3 (.pos(r3), .en(step_en), .pos_next(r3_next));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A new accept always refills the register, so back-to-back traffic keeps
  // it FULL; it only empties when the entry leaves and nothing replaces it.
  always_comb begin
    state_next = state;
    unique case (state)
      OUT_EMPTY: begin
        if (accept) state_next = OUT_FULL;
      end
      OUT_FULL: begin
        if (accept) begin
          state_next = OUT_FULL;
        end else if (out_ready) begin
          state_next = OUT_EMPTY;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // Load and accept never coincide because in_ready is low during load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else if (load) begin
      if (init_ok) begin
        r1 <= r1_init;
        r2 <= r2_init;
        r3 <= r3_init;
      end
    end else if (accept) begin
      r1 <= r1_next;
      r2 <= r2_next;
      r3 <= r3_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err <= 1'b0;
    end else if (load) begin
      load_err <= !init_ok;
    end
  end

  // Written only on accept, so a stalled entry stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_char <= '0;
      r1_out   <= '0;
      r2_out   <= '0;
      r3_out   <= '0;
      out_err  <= 1'b0;
    end else if (accept) begin
      out_char <= in_char;
      r1_out   <= r1_next;
      r2_out   <= r2_next;
      r3_out   <= r3_next;
      out_err  <= !char_ok;
    end
  end

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Self-checking bench for rotor_step_ctrl.
//
// Expected output entries are written by hand from the stepping rules and
// queued at the moment the bench expects the character to be accepted; the
// head of the queue is compared every cycle the output register is full.
module tb_rotor_step_ctrl;
  import enigma_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    load;
  letter_t r1_init, r2_init, r3_init;
  logic    in_valid;
  letter_t in_char;
  logic    in_ready;
  logic    out_valid;
  logic    out_ready;
  letter_t out_char;
  letter_t r1_out, r2_out, r3_out;
  logic    out_err;
  logic    load_err;

  always #5 clk = ~clk;

  rotor_step_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .r1_init   (r1_init),
    .r2_init   (r2_init),
    .r3_init   (r3_init),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .r1_out    (r1_out),
    .r2_out    (r2_out),
    .r3_out    (r3_out),
    .out_err   (out_err),
    .load_err  (load_err)
  );

  typedef struct packed {
    letter_t ch;
    letter_t r1;
    letter_t r2;
    letter_t r3;
    logic    err;
  } entry_t;

  entry_t sb[$];
  entry_t pend;
  logic   accepted;
  logic   m_full;
  logic   m_load_err;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Compare the output register against explicit values.
  task automatic checkOutput(input string tag, input letter_t ch, input letter_t e1,
                             input letter_t e2, input letter_t e3, input logic ee);
    check({tag, ".out_char"}, out_char, ch);
    check({tag, ".r1_out"}, r1_out, e1);
    check({tag, ".r2_out"}, r2_out, e2);
    check({tag, ".r3_out"}, r3_out, e3);
    check({tag, ".out_err"}, out_err, ee);
  endtask

  // One clock: check handshake/flags mid-cycle, compare the queue head,
  // then advance the occupancy model for the coming edge.
  task automatic cycle();
    logic exp_ready;
    @(negedge clk);
    exp_ready = !load && (!m_full || out_ready);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_full);
    check("load_err", load_err, m_load_err);
    if (m_full && sb.size() > 0) begin
      checkOutput("entry", sb[0].ch, sb[0].r1, sb[0].r2, sb[0].r3, sb[0].err);
      if (out_ready && !rst) void'(sb.pop_front());
    end
    accepted = 1'b0;
    if (rst) begin
      sb.delete();
      m_full     = 1'b0;
      m_load_err = 1'b0;
    end else begin
      if (load) m_load_err = (r1_init > 5'd25) || (r2_init > 5'd25) || (r3_init > 5'd25);
      if (in_valid && exp_ready) begin
        sb.push_back(pend);
        m_full   = 1'b1;
        accepted = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one character until accepted; queue its expected output entry.
  task automatic applyStimulus(input letter_t c, input letter_t e1, input letter_t e2,
                               input letter_t e3, input logic ee);
    in_valid = 1'b1;
    in_char  = c;
    pend     = '{ch: c, r1: e1, r2: e2, r3: e3, err: ee};
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) cycle();
    in_valid = 1'b0;
  endtask

  task automatic doLoad(input letter_t a, input letter_t b, input letter_t c);
    load    = 1'b1;
    r1_init = a;
    r2_init = b;
    r3_init = c;
    cycle();
    load = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 8 && m_full; i++) cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    r1_init    = '0;
    r2_init    = '0;
    r3_init    = '0;
    in_valid   = 1'b0;
    in_char    = '0;
    out_ready  = 1'b0;
    m_full     = 1'b0;
    m_load_err = 1'b0;
    accepted   = 1'b0;
    pend       = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    checkOutput("reset", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Plain stepping, one character per cycle.
    out_ready = 1'b1;
    doLoad(5'd0, 5'd0, 5'd0);
    applyStimulus(5'd7, 5'd0, 5'd0, 5'd1, 1'b0);
    applyStimulus(5'd8, 5'd0, 5'd0, 5'd2, 1'b0);
    applyStimulus(5'd9, 5'd0, 5'd0, 5'd3, 1'b0);
    drain();

    // Double step: ADU -> ADV -> AEW -> BFX.
    doLoad(5'd0, 5'd3, 5'd20);
    applyStimulus(5'd1, 5'd0, 5'd3, 5'd21, 1'b0);
    applyStimulus(5'd2, 5'd0, 5'd4, 5'd22, 1'b0);
    applyStimulus(5'd3, 5'd1, 5'd5, 5'd23, 1'b0);
    drain();

    // Mod-26 wraps on each rotor.
    doLoad(5'd0, 5'd0, 5'd25);
    applyStimulus(5'd25, 5'd0, 5'd0, 5'd0, 1'b0);
    doLoad(5'd25, 5'd4, 5'd0);
    applyStimulus(5'd4, 5'd0, 5'd5, 5'd1, 1'b0);
    doLoad(5'd0, 5'd25, 5'd21);
    applyStimulus(5'd6, 5'd0, 5'd0, 5'd22, 1'b0);
    doLoad(5'd0, 5'd4, 5'd21);
    applyStimulus(5'd6, 5'd1, 5'd5, 5'd22, 1'b0);
    drain();

    // Backpressure: first entry held, second char stalled, no extra step.
    doLoad(5'd0, 5'd0, 5'd0);
    out_ready = 1'b0;
    applyStimulus(5'd2, 5'd0, 5'd0, 5'd1, 1'b0);
    in_valid = 1'b1;
    in_char  = 5'd3;
    pend     = '{ch: 5'd3, r1: 5'd0, r2: 5'd0, r3: 5'd2, err: 1'b0};
    repeat (3) cycle();
    out_ready = 1'b1;
    applyStimulus(5'd3, 5'd0, 5'd0, 5'd2, 1'b0);
    drain();

    // Illegal character, then illegal load; positions must not move.
    applyStimulus(5'd27, 5'd0, 5'd0, 5'd2, 1'b1);
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd3, 1'b0);
    doLoad(5'd0, 5'd26, 5'd0);
    applyStimulus(5'd11, 5'd0, 5'd0, 5'd4, 1'b0);
    drain();

    // Load wins over a same-cycle character and clears load_err.
    in_valid = 1'b1;
    in_char  = 5'd13;
    doLoad(5'd1, 5'd1, 5'd1);
    in_valid = 1'b0;
    applyStimulus(5'd13, 5'd1, 5'd1, 5'd2, 1'b0);
    drain();

    // Reset while FULL with a pending character discards everything.
    doLoad(5'd0, 5'd26, 5'd0);
    out_ready = 1'b0;
    applyStimulus(5'd14, 5'd1, 5'd1, 5'd3, 1'b0);
    in_valid = 1'b1;
    in_char  = 5'd5;
    rst      = 1'b1;
    cycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("out_valid_after_rst", out_valid, 1'b0);
    check("load_err_after_rst", load_err, 1'b0);
    checkOutput("after_rst", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    out_ready = 1'b1;
    applyStimulus(5'd20, 5'd0, 5'd0, 5'd1, 1'b0);
    drain();
    cycle();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
